// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one uart_tx between two byte requesters using a valid/ready
//   handshake. A winner is chosen combinationally while idle, its byte is
//   latched and a one-cycle start pulse is issued to the transmitter. The
//   transmitter has no busy output, so the frame (plus an optional idle gap)
//   is timed here by counting baud_tick pulses.
//
//   Parameters
//     FRAME_TICKS  baud_ticks per frame (start + 8 data + stop + 1 alignment)
//     GAP_TICKS    extra idle baud_ticks enforced after each frame (0..255)
//
//   Ports
//     clk, rst_n               clock; synchronous active-low reset
//     baud_tick                1-cycle pulse from the shared baud generator
//     req0_valid/data/ready    requester 0 handshake (ready = accepted now)
//     req1_valid/data/ready    requester 1 handshake
//     tx_start, tx_data        start pulse and byte to uart_tx
//     busy                     high from accept until back in IDLE
//     grant_id                 requester owning the current or last frame
//     frame_done               1-cycle pulse once frame plus gap has elapsed
//
//   Configuration macro
//     UART_ARB_FIXED_PRIO_EN   when defined, req0 always beats req1 (a
//                              continuously valid req0 starves req1). When
//                              undefined, the two requesters alternate.
module uart_tx_arbiter #(
    parameter int FRAME_TICKS = 11,
    parameter int GAP_TICKS   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       baud_tick,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       grant_id,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WAIT   = 3'd2,
        GAP    = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [7:0] FRAME_LAST = 8'(FRAME_TICKS - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_TICKS - 1);

    state_t     state_r;
    logic [7:0] tick_cnt_r;
    logic       win0_s;
    logic       win1_s;
`ifndef UART_ARB_FIXED_PRIO_EN
    logic       last_grant_r;
`endif

    // Pick the requester that would be accepted if the block is idle.
    always_comb begin
        win0_s = 1'b0;
        win1_s = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef UART_ARB_FIXED_PRIO_EN
            win0_s = 1'b1;
`else
            // On a tie the requester that did not own the last frame wins.
            if (last_grant_r) begin
                win0_s = 1'b1;
            end else begin
                win1_s = 1'b1;
            end
`endif
        end else if (req0_valid) begin
            win0_s = 1'b1;
        end else if (req1_valid) begin
            win1_s = 1'b1;
        end else begin
            win0_s = 1'b0;
            win1_s = 1'b0;
        end
    end

    assign req0_ready = (state_r == IDLE) && win0_s;
    assign req1_ready = (state_r == IDLE) && win1_s;

    // Frame sequencer: accept, launch, time frame and gap, report completion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            tick_cnt_r   <= 8'h00;
            tx_start     <= 1'b0;
            tx_data      <= 8'h00;
            busy         <= 1'b0;
            grant_id     <= 1'b0;
            frame_done   <= 1'b0;
`ifndef UART_ARB_FIXED_PRIO_EN
            last_grant_r <= 1'b1;
`endif
        end else begin
            tx_start   <= 1'b0;
            frame_done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (win0_s || win1_s) begin
                        tx_data      <= win1_s ? req1_data : req0_data;
                        grant_id     <= win1_s;
`ifndef UART_ARB_FIXED_PRIO_EN
                        last_grant_r <= win1_s;
`endif
                        busy         <= 1'b1;
                        tx_start     <= 1'b1;
                        state_r      <= LAUNCH;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LAUNCH: begin
                    // A baud_tick landing here belongs to no frame slot yet.
                    tick_cnt_r <= 8'h00;
                    state_r    <= WAIT;
                end
                WAIT: begin
                    if (baud_tick) begin
                        if (tick_cnt_r == FRAME_LAST) begin
                            tick_cnt_r <= 8'h00;
                            if (GAP_TICKS == 0) begin
                                frame_done <= 1'b1;
                                state_r    <= DONE;
                            end else begin
                                state_r <= GAP;
                            end
                        end else begin
                            tick_cnt_r <= tick_cnt_r + 8'd1;
                        end
                    end else begin
                        state_r <= WAIT;
                    end
                end
                GAP: begin
                    if (baud_tick) begin
                        if (tick_cnt_r == GAP_LAST) begin
                            tick_cnt_r <= 8'h00;
                            frame_done <= 1'b1;
                            state_r    <= DONE;
                        end else begin
                            tick_cnt_r <= tick_cnt_r + 8'd1;
                        end
                    end else begin
                        state_r <= GAP;
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    tick_cnt_r <= 8'h00;
                    busy       <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: two instances (GAP_TICKS 0 and 3) share one
// stimulus stream. A transaction-level model (frame = fixed number of baud
// ticks counted after the launch cycle) predicts every output each cycle.
module tb_uart_tx_arbiter;

    localparam int FT = 11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       baud_tick = 1'b0;
    logic       req0_valid = 1'b0;
    logic       req1_valid = 1'b0;
    logic [7:0] req0_data = 8'h00;
    logic [7:0] req1_data = 8'h00;

    logic [1:0]      r0_o, r1_o, ts_o, busy_o, gid_o, fd_o;
    logic [1:0][7:0] td_o;

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx_arbiter #(.FRAME_TICKS(FT), .GAP_TICKS(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(r0_o[0]),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(r1_o[0]),
        .tx_start(ts_o[0]), .tx_data(td_o[0]), .busy(busy_o[0]),
        .grant_id(gid_o[0]), .frame_done(fd_o[0])
    );

    uart_tx_arbiter #(.FRAME_TICKS(FT), .GAP_TICKS(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(r0_o[1]),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(r1_o[1]),
        .tx_start(ts_o[1]), .tx_data(td_o[1]), .busy(busy_o[1]),
        .grant_id(gid_o[1]), .frame_done(fd_o[1])
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", name, idx, $time, act, exp);
        end
    endtask

    // Reference arbitration: returns 1 when requester 1 must be granted.
    function automatic bit pick1(input bit v0, input bit v1, input bit last);
        if (v0 && v1) begin
`ifdef UART_ARB_FIXED_PRIO_EN
            return 1'b0;
`else
            return !last;
`endif
        end
        return v1 && !v0;
    endfunction

    // Model state per instance
    bit       model_ok = 1'b0;
    bit       m_active [2];
    int       m_since  [2];
    int       m_ticks  [2];
    bit       m_done   [2];
    logic [7:0] m_data [2];
    bit       m_gid    [2];
    bit       m_last   [2];

    // Literal-expectation monitors
    int  tk      [2];
    bit  started [2];
    int  rr_cnt  [2];
    bit  rr_mode  = 1'b0;
    bit  b2b_mode = 1'b0;

    // Per-cycle compare against the model, then advance the model.
    always @(negedge clk) begin
        bit w;
        int total;
        int exp_g;
        for (int i = 0; i < 2; i++) begin
            total = FT + ((i == 0) ? 0 : 3);
            if (model_ok) begin
                w = pick1(req0_valid, req1_valid, m_last[i]);
                check("req0_ready", i, 32'(r0_o[i]), 32'(!m_active[i] && req0_valid && !w));
                check("req1_ready", i, 32'(r1_o[i]), 32'(!m_active[i] && req1_valid && w));
                check("tx_start",   i, 32'(ts_o[i]), 32'(m_active[i] && m_since[i] == 1));
                check("busy",       i, 32'(busy_o[i]), 32'(m_active[i]));
                check("frame_done", i, 32'(fd_o[i]), 32'(m_active[i] && m_done[i]));
                check("tx_data",    i, 32'(td_o[i]), 32'(m_data[i]));
                check("grant_id",   i, 32'(gid_o[i]), 32'(m_gid[i]));

                if (fd_o[i] === 1'b1) check("frame_ticks", i, 32'(tk[i]), (i == 0) ? 32'd11 : 32'd14);
                if (ts_o[i] === 1'b1) begin
                    if (b2b_mode && started[i]) check("start_spacing", i, 32'(tk[i]), (i == 0) ? 32'd11 : 32'd14);
                    if (rr_mode) begin
`ifdef UART_ARB_FIXED_PRIO_EN
                        exp_g = 0;
`else
                        exp_g = rr_cnt[i] % 2;
`endif
                        check("rr_grant", i, 32'(gid_o[i]), 32'(exp_g));
                        check("rr_data",  i, 32'(td_o[i]), (exp_g == 1) ? 32'h3C : 32'hA5);
                        rr_cnt[i]++;
                    end
                    started[i] = 1'b1;
                    tk[i] = 0;
                end else if (baud_tick) begin
                    tk[i]++;
                end
            end
            if (!rst_n) begin
                started[i] = 1'b0;
                tk[i] = 0;
            end

            // Advance: what the state must be after the coming clock edge.
            if (!rst_n) begin
                m_active[i] = 1'b0; m_since[i] = 0; m_ticks[i] = 0; m_done[i] = 1'b0;
                m_data[i] = 8'h00; m_gid[i] = 1'b0; m_last[i] = 1'b1;
            end else if (!m_active[i]) begin
                if (req0_valid || req1_valid) begin
                    w = pick1(req0_valid, req1_valid, m_last[i]);
                    m_data[i] = w ? req1_data : req0_data;
                    m_gid[i] = w; m_last[i] = w;
                    m_active[i] = 1'b1; m_since[i] = 1; m_ticks[i] = 0; m_done[i] = 1'b0;
                end
            end else if (m_done[i]) begin
                m_active[i] = 1'b0; m_done[i] = 1'b0;
            end else begin
                // Launch cycle (since==1) never counts a tick.
                if (m_since[i] >= 2 && baud_tick) begin
                    m_ticks[i]++;
                    if (m_ticks[i] == total) m_done[i] = 1'b1;
                end
                m_since[i]++;
            end
        end
        model_ok = 1'b1;
    end

    int bph = 0;

    task automatic step();
        @(posedge clk);
        #1;
        bph = (bph + 1) % 4;
        baud_tick = (bph == 0);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy_o != 2'b00 && n < budget) begin
            step();
            n++;
        end
        if (busy_o != 2'b00) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, expected 00", busy_o, budget);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    initial begin
        bit a0, a1, s0, s1;
        int k;

        // Reset values
        do_reset();
        for (int i = 0; i < 2; i++) begin
            check("rst_busy", i, 32'(busy_o[i]), 32'd0);
            check("rst_data", i, 32'(td_o[i]), 32'h00);
            check("rst_gid",  i, 32'(gid_o[i]), 32'd0);
            check("rst_start", i, 32'(ts_o[i]), 32'd0);
            check("rst_done", i, 32'(fd_o[i]), 32'd0);
        end

        // Single request at each baud phase (covers a tick in the launch cycle)
        for (int ph = 0; ph < 4; ph++) begin
            repeat (ph + 1) step();
            req0_valid = 1'b1; req0_data = 8'h05;
            step();
            req0_valid = 1'b0;
            for (int i = 0; i < 2; i++) begin
                check("t1_start", i, 32'(ts_o[i]), 32'd1);
                check("t1_data",  i, 32'(td_o[i]), 32'h05);
                check("t1_gid",   i, 32'(gid_o[i]), 32'd0);
            end
            wait_idle(200);
        end

        // Both requesters held: alternating grants
        do_reset();
        rr_cnt[0] = 0; rr_cnt[1] = 0;
        rr_mode = 1'b1;
        req0_valid = 1'b1; req0_data = 8'hA5;
        req1_valid = 1'b1; req1_data = 8'h3C;
        k = 0;
        while ((rr_cnt[0] < 4 || rr_cnt[1] < 4) && k < 1000) begin step(); k++; end
        check("rr_frames", 0, 32'(rr_cnt[0] >= 4 && rr_cnt[1] >= 4), 32'd1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle(200);
        rr_mode = 1'b0;

        // req1 raised while req0's frame is in flight
        req0_valid = 1'b1; req0_data = 8'h21;
        step();
        req0_valid = 1'b0;
        repeat (6) step();
        req1_valid = 1'b1; req1_data = 8'h5A;
        s0 = 1'b0; s1 = 1'b0; k = 0;
        while (!(s0 && s1) && k < 400) begin
            a0 = r1_o[0]; a1 = r1_o[1];
            s0 = s0 | a0; s1 = s1 | a1;
            step();
            k++;
        end
        check("t3_accepted", 0, 32'(s0 && s1), 32'd1);
        req1_valid = 1'b0;
        wait_idle(200);

        // Reset in the middle of a frame
        req0_valid = 1'b1; req0_data = 8'h11;
        step();
        req0_valid = 1'b0;
        k = 0;
        while (k < 5) begin step(); if (baud_tick) k++; end
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check("t4_busy", i, 32'(busy_o[i]), 32'd0);
            check("t4_data", i, 32'(td_o[i]), 32'h00);
            check("t4_done", i, 32'(fd_o[i]), 32'd0);
        end
        req0_valid = 1'b1; req0_data = 8'h7E;
        step();
        req0_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("t4_start", i, 32'(ts_o[i]), 32'd1);
            check("t4_newdata", i, 32'(td_o[i]), 32'h7E);
        end
        wait_idle(200);

        // Back-to-back frames from req0
        do_reset();
        b2b_mode = 1'b1;
        req0_valid = 1'b1; req0_data = 8'h42;
        repeat (400) step();
        req0_valid = 1'b0;
        wait_idle(200);
        b2b_mode = 1'b0;

        // Randomised traffic with withdrawals and occasional resets
        for (int c = 0; c < 4000; c++) begin
            a0 = req0_valid & r0_o[0];
            a1 = req1_valid & r1_o[0];
            step();
            if (a0 || !req0_valid) begin
                req0_valid = ($urandom_range(0, 2) == 0);
                req0_data = 8'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                req0_valid = 1'b0;
            end
            if (a1 || !req1_valid) begin
                req1_valid = ($urandom_range(0, 2) == 0);
                req1_data = 8'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                req1_valid = 1'b0;
            end
            rst_n = ($urandom_range(0, 399) != 0);
        end
        rst_n = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle(400);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
